// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle between two requesters, the shared ALU and its consumer
//   i_reqK_valid/o_reqK_ready/i_reqK_op/i_reqK_a/i_reqK_b : request port K (K = 0, 1)
//   o_rsp_valid/i_rsp_ready/o_rsp_id/o_rsp_data/o_rsp_err  : registered result port
//   slave modport = ALU side, master modport = requester/consumer side
interface alu_share_arbiter_if #(parameter int DATA_W = 32);
   logic              i_req0_valid;
   logic              o_req0_ready;
   logic [3:0]        i_req0_op;
   logic [DATA_W-1:0] i_req0_a;
   logic [DATA_W-1:0] i_req0_b;
   logic              i_req1_valid;
   logic              o_req1_ready;
   logic [3:0]        i_req1_op;
   logic [DATA_W-1:0] i_req1_a;
   logic [DATA_W-1:0] i_req1_b;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic              o_rsp_id;
   logic [DATA_W-1:0] o_rsp_data;
   logic              o_rsp_err;
   modport slave (
      input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
      input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
      input  i_rsp_ready,
      output o_req0_ready, o_req1_ready,
      output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
   );
   modport master (
      output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
      output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
      output i_rsp_ready,
      input  o_req0_ready, o_req1_ready,
      input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one registered ALU shared round-robin between two requesters
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : alu_share_arbiter_if.slave carrying both request ports and the result port
module alu_share_arbiter #(
   parameter int DATA_W = 32
) (
   input logic                 i_clk,
   input logic                 i_rst,
   alu_share_arbiter_if.slave  bus
);
   localparam int SH_W = $clog2(DATA_W);
   logic              valid_q, id_q, err_q, prio_q;
   logic [DATA_W-1:0] data_q, data_d;
   logic              id_d, err_d;
   logic              can_load, rdy0, rdy1, fire0, fire1;
   logic [3:0]        op;
   logic [DATA_W-1:0] a, b;
   logic [SH_W-1:0]   sh;
   // the output register may be refilled in the same cycle its result is consumed
   assign can_load = ~valid_q | bus.i_rsp_ready;
   // a requester is held off only when the other one is valid and currently has priority
   assign rdy0  = can_load & ~i_rst & ~(bus.i_req1_valid & prio_q);
   assign rdy1  = can_load & ~i_rst & ~(bus.i_req0_valid & ~prio_q);
   assign fire0 = bus.i_req0_valid & rdy0;
   assign fire1 = bus.i_req1_valid & rdy1;
   always_comb begin
      op    = fire1 ? bus.i_req1_op : bus.i_req0_op;
      a     = fire1 ? bus.i_req1_a  : bus.i_req0_a;
      b     = fire1 ? bus.i_req1_b  : bus.i_req0_b;
      sh    = b[SH_W-1:0];
      id_d  = fire1;
      err_d = op > 4'd9;
      case (op)
         4'd0:    data_d = a + b;
         4'd1:    data_d = a - b;
         4'd2:    data_d = a << sh;
         4'd3:    data_d = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
         4'd4:    data_d = {{(DATA_W-1){1'b0}}, a < b};
         4'd5:    data_d = a ^ b;
         4'd6:    data_d = a >> sh;
         4'd7:    data_d = $signed(a) >>> sh;
         4'd8:    data_d = a | b;
         4'd9:    data_d = a & b;
         default: data_d = '0;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else if (fire0 | fire1) begin
         valid_q <= 1'b1;
         data_q  <= data_d;
         id_q    <= id_d;
         err_q   <= err_d;
         // priority passes to the requester that did not just transfer
         prio_q  <= fire0;
      end else if (bus.i_rsp_ready) begin
         valid_q <= 1'b0;
      end
   end
   assign bus.o_req0_ready = rdy0;
   assign bus.o_req1_ready = rdy1;
   assign bus.o_rsp_valid  = valid_q;
   assign bus.o_rsp_id     = id_q;
   assign bus.o_rsp_data   = data_q;
   assign bus.o_rsp_err    = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for the shared ALU arbiter
module tb_alu_share_arbiter;
   typedef struct packed {
      logic        id;
      logic        err;
      logic [31:0] data;
   } rsp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   gnt = -1;
   rsp_t sb[$];
   alu_share_arbiter_if #(.DATA_W(32)) bus ();
   alu_share_arbiter #(.DATA_W(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic rsp_t model(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      rsp_t r;
      logic [4:0] s;
      s = b[4:0];
      r.id = id;
      r.err = 1'b0;
      case (op)
         4'd0: r.data = a + b;
         4'd1: r.data = a + ~b + 32'd1;
         4'd2: r.data = a << s;
         4'd3: r.data = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
         4'd4: r.data = {31'd0, a < b};
         4'd5: r.data = a ^ b;
         4'd6: r.data = a >> s;
         4'd7: r.data = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
         4'd8: r.data = a | b;
         4'd9: r.data = a & b;
         default: begin r.data = 32'd0; r.err = 1'b1; end
      endcase
      return r;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask
   // one clock: score the response port and push accepted requests, then advance past the edge
   task automatic step();
      rsp_t e;
      @(negedge clk);
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.o_rsp_valid && bus.i_rsp_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               failures++;
               $error("FAIL sb_unexpected got=%08h exp=none", bus.o_rsp_data);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_id", {31'd0, bus.o_rsp_id}, {31'd0, e.id});
               chk("sb_err", {31'd0, bus.o_rsp_err}, {31'd0, e.err});
               chk("sb_data", bus.o_rsp_data, e.data);
            end
         end
         if (bus.i_req0_valid && bus.o_req0_ready && bus.i_req1_valid && bus.o_req1_ready)
            chk("double_grant", 32'd1, 32'd0);
         if (bus.i_req0_valid && bus.o_req0_ready) begin
            sb.push_back(model(1'b0, bus.i_req0_op, bus.i_req0_a, bus.i_req0_b));
            gnt = 0;
         end
         if (bus.i_req1_valid && bus.o_req1_ready) begin
            sb.push_back(model(1'b1, bus.i_req1_op, bus.i_req1_a, bus.i_req1_b));
            gnt = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic req0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.i_req0_valid = v;
      bus.i_req0_op = op;
      bus.i_req0_a = a;
      bus.i_req0_b = b;
   endtask
   task automatic req1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.i_req1_valid = v;
      bus.i_req1_op = op;
      bus.i_req1_a = a;
      bus.i_req1_b = b;
   endtask
   initial begin
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      bus.i_rsp_ready = 1'b1;
      step();
      step();
      chk("rst_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
      chk("rst_data", bus.o_rsp_data, 32'd0);
      chk("rst_id", {31'd0, bus.o_rsp_id}, 32'd0);
      chk("rst_err", {31'd0, bus.o_rsp_err}, 32'd0);
      chk("rst_rdy0", {31'd0, bus.o_req0_ready}, 32'd0);
      chk("rst_rdy1", {31'd0, bus.o_req1_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_rdy0", {31'd0, bus.o_req0_ready}, 32'd1);
      chk("idle_rdy1", {31'd0, bus.o_req1_ready}, 32'd1);
      // single op with overflow wrap into the sign bit
      req0(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1);
      step();
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      chk("add_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
      chk("add_data", bus.o_rsp_data, 32'h8000_0000);
      chk("add_id", {31'd0, bus.o_rsp_id}, 32'd0);
      chk("add_err", {31'd0, bus.o_rsp_err}, 32'd0);
      // lone req1 op returns priority to requester 0
      req1(1'b1, 4'd3, 32'd1, 32'hFFFF_FFFF);
      step();
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      chk("slt_data", bus.o_rsp_data, 32'd0);
      chk("slt_id", {31'd0, bus.o_rsp_id}, 32'd1);
      step();
      chk("drain_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
      // contention: grants alternate starting with requester 0
      req0(1'b1, 4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000);
      req1(1'b1, 4'd1, 32'd5, 32'd7);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_gnt", gnt, i % 2);
         chk("rr_data", bus.o_rsp_data, (i % 2) ? 32'hFFFF_FFFE : 32'h0F0F_F0F0);
      end
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      // back-pressure: result held, both requesters waiting
      req0(1'b1, 4'd4, 32'd1, 32'hFFFF_FFFF);
      step();
      bus.i_rsp_ready = 1'b0;
      req0(1'b1, 4'd7, 32'h8000_0000, 32'h24);
      req1(1'b1, 4'd8, 32'h1200_0034, 32'h0056_0000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_rdy0", {31'd0, bus.o_req0_ready}, 32'd0);
         chk("bp_rdy1", {31'd0, bus.o_req1_ready}, 32'd0);
         chk("bp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
         chk("bp_data", bus.o_rsp_data, 32'd1);
         chk("bp_id", {31'd0, bus.o_rsp_id}, 32'd0);
      end
      bus.i_rsp_ready = 1'b1;
      #1;
      chk("bp_release_rdy1", {31'd0, bus.o_req1_ready}, 32'd1);
      chk("bp_release_rdy0", {31'd0, bus.o_req0_ready}, 32'd0);
      step();
      chk("bp_reload_id", {31'd0, bus.o_rsp_id}, 32'd1);
      chk("or_data", bus.o_rsp_data, 32'h1256_0034);
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      chk("sra_data", bus.o_rsp_data, 32'hF800_0000);
      // illegal opcode followed by a legal one
      req1(1'b1, 4'hC, 32'hDEAD_BEEF, 32'h1234_5678);
      step();
      chk("ill_data", bus.o_rsp_data, 32'd0);
      chk("ill_err", {31'd0, bus.o_rsp_err}, 32'd1);
      chk("ill_id", {31'd0, bus.o_rsp_id}, 32'd1);
      req1(1'b1, 4'd2, 32'h0000_0003, 32'h0000_0021);
      step();
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      chk("legal_err", {31'd0, bus.o_rsp_err}, 32'd0);
      chk("sll_data", bus.o_rsp_data, 32'h0000_0006);
      req0(1'b1, 4'd6, 32'h8000_0000, 32'd31);
      step();
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      chk("srl_data", bus.o_rsp_data, 32'd1);
      req1(1'b1, 4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0);
      step();
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      // reset while a result is stalled; priority was left pointing at requester 1
      bus.i_rsp_ready = 1'b0;
      req0(1'b1, 4'd0, 32'd2, 32'd3);
      step();
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      chk("pre_rst_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
      rst = 1'b1;
      step();
      chk("rst2_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
      chk("rst2_rdy0", {31'd0, bus.o_req0_ready}, 32'd0);
      rst = 1'b0;
      bus.i_rsp_ready = 1'b1;
      step();
      chk("no_stale", {31'd0, bus.o_rsp_valid}, 32'd0);
      req0(1'b1, 4'd0, 32'd10, 32'd20);
      req1(1'b1, 4'd0, 32'd30, 32'd40);
      gnt = -1;
      step();
      chk("rst_prio_gnt", gnt, 32'd0);
      req0(1'b0, 4'd0, 32'd0, 32'd0);
      req1(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
